alu_seq_pipe: RTL
=================

Name: alu_seq_pipe

Overview:
Parametrised, handshaked successor to the generated combinational ALUs. Latches one operation per transaction, executes it over one or more cycles and holds a registered result plus flags until the consumer accepts it. Adds shifts, implemented signed compares, an overflow flag and an illegal-opcode flag. Sits between an operand-issue stage and a result-writeback stage.

Parameters:
WIDTH, 32, datapath width; power of two, 8..64
SHW, clog2(WIDTH), shift-amount width; derived localparam, not overridable

Ports:
clk  in  1  sole clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept (high only in IDLE)
opcode  in  4  operation select
input1  in  WIDTH  operand A
input2  in  WIDTH  operand B
shift_amt  in  SHW  shift distance for SLL/SRL/SRA
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
carry_flag  out  1  carry/borrow/last bit shifted out
zero_flag  out  1  result == 0
sign_flag  out  1  result[WIDTH-1]
overflow_flag  out  1  signed overflow (ADD/SUB only)
illegal_op  out  1  opcode not in table
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, in_ready=1 after deassertion, out_valid=0, result=0, all flags=0, shift counter=0, latched operands=0. Reset mid-operation aborts the operation; no partial result is delivered.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SGE, 5 SGT, 6 XOR, 7 SLL, 8 SRL, 9 SRA; 10..15 illegal.
- Accept: in_valid && in_ready at edge T. opcode, input1, input2 and shift_amt are latched at T. Later input changes are ignored.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on accept of a non-shift op, or a shift with shift_amt=0, compute and go to DONE. out_valid is asserted at T+1.
  - IDLE: on accept of a shift with shift_amt=s>0, load counter=s and go to SHIFT.
  - SHIFT: moves one bit per cycle and decrements the counter. After the cycle where counter==1, go to DONE. out_valid is asserted at T+1+s.
  - DONE: out_valid=1. result and flags are held stable while !out_ready. When out_ready=1, go to IDLE next cycle, with out_valid=0 and in_ready=1.
- No overlap: in_ready=0 in SHIFT and DONE. Maximum throughput is 1 op per 2 cycles.
- Arithmetic:
  - ADD: {carry,result} = A+B in WIDTH+1 bits.
  - SUB: result = A-B. carry=1 when A<B unsigned (borrow).
  - overflow: ADD when A and B have the same sign and result sign differs; SUB when A and B signs differ and result sign != A sign. overflow=0 for all other ops.
  - SGE/SGT: signed compare; result = {WIDTH-1 zeros, cmp}. carry=0.
  - AND/OR/XOR: carry=0.
  - SLL/SRL: zero fill. SRA: sign fill. carry = last bit shifted out (0 when s=0). SRA on a negative value keeps the sign across all s.
  - illegal: result=0, illegal_op=1, carry=overflow=0, zero_flag=1.
- zero_flag and sign_flag are derived from the final result and registered with it.
- Result and flag outputs keep their last values after the handshake until the next result is written. Only out_valid qualifies them.

Optional Feature:
ALU_BARREL_SHIFT_EN. Defined: shifts are computed by a single-cycle barrel shifter; latency is 1 for every op; the SHIFT state and counter are not built, and results and flags are identical. Undefined: serial shifter as above, with latency 1+shift_amt.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001, accepted at T -> out_valid at T+1; result 0x00000000; carry=1, zero=1, overflow=0, sign=0.
- SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF; overflow=1, carry=0, sign=0. SUB 0x00000001 - 0x00000002 -> result 0xFFFFFFFF; carry=1, sign=1.
- SGT A=0xFFFFFFFF, B=0x00000001 -> result 0. SGE A=5, B=5 -> result 1. Opcode 12 -> result 0; illegal_op=1, zero=1.
- SRA 0x80000000, shift_amt=4, accepted at T -> in_ready=0 from T+1 through DONE; out_valid at T+5; result 0xF8000000; carry=0. SLL 0x80000001, shift_amt=1 -> out_valid at T+2; result 0x00000002; carry=1. With ALU_BARREL_SHIFT_EN both ops produce out_valid at T+1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands -> result and flags stay constant; in_ready=0; new op not accepted. On out_ready=1, the next cycle has in_ready=1.
- Assert rst_n=0 during SHIFT with counter=3 -> out_valid=0 and busy=0 immediately (asynchronous); after release in_ready=1; a following ADD 2+3 returns 5 at T+1.

Source files
------------

// File: rtl/alu_seq_pipe.sv
// alu_seq_pipe: handshaked sequential ALU.
// Latches one operation per transaction, executes it in one or more cycles
// and holds a registered result plus flags until the consumer accepts it.
// Optional build macro: ALU_BARREL_SHIFT_EN.
//   Defined   -> shifts use a single-cycle barrel shifter, latency 1 for all ops.
//   Undefined -> shifts move one bit per cycle, latency 1 + shift_amt.
module alu_seq_pipe #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             sign_flag,
    output logic             overflow_flag,
    output logic             illegal_op,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SGE = 4'd4;
    localparam logic [3:0] OP_SGT = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             ill;
    } alu_out_t;

    // Full single-cycle evaluation of any opcode. Shifts are done on a
    // WIDTH+1 wide vector so the extra bit captures the last bit shifted out
    // (which is naturally 0 when the shift distance is 0).
    function automatic alu_out_t alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [SHW-1:0]   s
    );
        alu_out_t               o;
        logic [WIDTH:0]         wide;
        logic signed [WIDTH:0]  wide_s;
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        o      = '0;
        wide   = '0;
        wide_s = '0;
        sa     = $signed(a);
        sb     = $signed(b);
        case (op)
            OP_ADD: begin
                wide    = {1'b0, a} + {1'b0, b};
                o.res   = wide[WIDTH-1:0];
                o.carry = wide[WIDTH];
                o.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The wrap into bit WIDTH is exactly the unsigned borrow.
                wide    = {1'b0, a} - {1'b0, b};
                o.res   = wide[WIDTH-1:0];
                o.carry = wide[WIDTH];
                o.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: o.res = a & b;
            OP_OR:  o.res = a | b;
            OP_XOR: o.res = a ^ b;
            OP_SGE: o.res = {{(WIDTH-1){1'b0}}, (sa >= sb)};
            OP_SGT: o.res = {{(WIDTH-1){1'b0}}, (sa > sb)};
            OP_SLL: begin
                wide    = {1'b0, a} << s;
                o.res   = wide[WIDTH-1:0];
                o.carry = wide[WIDTH];
            end
            OP_SRL: begin
                wide    = {a, 1'b0} >> s;
                o.res   = wide[WIDTH:1];
                o.carry = wide[0];
            end
            OP_SRA: begin
                wide_s  = $signed({a, 1'b0}) >>> s;
                o.res   = wide_s[WIDTH:1];
                o.carry = wide_s[0];
            end
            default: o.ill = 1'b1;
        endcase
        return o;
    endfunction

`ifndef ALU_BARREL_SHIFT_EN
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // One serial shift step; returns {bit_shifted_out, next_value}.
    function automatic logic [WIDTH:0] shift_step(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] v
    );
        case (op)
            OP_SLL:  return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_SRL:  return {v[0], 1'b0, v[WIDTH-1:1]};
            default: return {v[0], v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    alu_out_t         eval;
    alu_out_t         wr;
    logic             wr_en;
`ifndef ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH:0]   step;
`endif

    // Next-state, shifter and result-write logic.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr      = '0;
        eval    = alu_eval(opcode, input1, input2, shift_amt);
`ifndef ALU_BARREL_SHIFT_EN
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        step    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift(opcode) && (shift_amt != '0)) begin
                        shreg_d = input1;
                        cnt_d   = shift_amt;
                        op_d    = opcode;
                        state_d = SHIFT;
                    end else
`endif
                    begin
                        wr_en   = 1'b1;
                        wr      = eval;
                        state_d = DONE;
                    end
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
                step    = shift_step(op_q, shreg_q);
                shreg_d = step[WIDTH-1:0];
                cnt_d   = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    wr_en    = 1'b1;
                    wr.res   = step[WIDTH-1:0];
                    wr.carry = step[WIDTH];
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result and flags only change when a new result is written.
        result_d = wr_en ? wr.res                   : result_q;
        carry_d  = wr_en ? wr.carry                 : carry_q;
        ovf_d    = wr_en ? wr.ovf                   : ovf_q;
        ill_d    = wr_en ? wr.ill                   : ill_q;
        zero_d   = wr_en ? (wr.res == '0)           : zero_q;
        sign_d   = wr_en ? wr.res[WIDTH-1]          : sign_q;
    end

    // State, result and flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            shreg_q  <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
`ifndef ALU_BARREL_SHIFT_EN
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
`endif
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign out_valid     = (state_q == DONE);
    assign result        = result_q;
    assign carry_flag    = carry_q;
    assign zero_flag     = zero_q;
    assign sign_flag     = sign_q;
    assign overflow_flag = ovf_q;
    assign illegal_op    = ill_q;

endmodule
